// File: rtl/led_matrix_ctrl_if.sv
// Flat register bus between the Wishbone LED adapter (master) and the
// LED matrix controller (slave): byte address, write data, write strobe
// and registered read data.
interface led_matrix_ctrl_if;
  logic [31:0] led_addr_i;
  logic [31:0] led_wdata_i;
  logic        led_we_i;
  logic [31:0] led_rdata_o;

  modport master (
    output led_addr_i,
    output led_wdata_i,
    output led_we_i,
    input  led_rdata_o
  );

  modport slave (
    input  led_addr_i,
    input  led_wdata_i,
    input  led_we_i,
    output led_rdata_o
  );
endinterface

// File: rtl/led_matrix_ctrl.sv
// 8x8 LED matrix controller: 8-row framebuffer, CTRL/STATUS registers with
// registered read data, and a row-multiplexed scan (OFF/BLANK/SHOW) with
// inter-row blanking. Each row's pixels are latched at the start of its SHOW
// phase, so writes never tear a lit row.
// Optional feature macro: LED_MATRIX_PWM_EN adds CTRL.BRIGHT[15:8] and a
// per-row PWM gate on the column drive; without it BRIGHT reads 0.
module led_matrix_ctrl #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  led_matrix_ctrl_if.slave   bus,
  output logic [7:0]         row_o,
  output logic [7:0]         col_o,
  output logic               frame_o
);

  localparam logic [15:0] SHOW_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {S_OFF, S_BLANK, S_SHOW} state_t;

  logic [7:0]  r_fb [8];
  logic        r_en;
  logic [7:0]  w_bright;
  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_idx, w_idx_nxt;
  logic [7:0]  r_fcnt, w_fcnt_nxt;
  logic [7:0]  r_latch, w_latch_nxt;
  logic        w_frame_nxt;
  logic        w_col_on;
  logic [7:0]  r_row, r_col;
  logic        r_frame;
  logic [31:0] r_rdata, w_rdata_nxt;
  logic [3:0]  w_widx;
  logic        w_unused;

  assign w_widx   = bus.led_addr_i[5:2];
  assign w_unused = &{1'b0, bus.led_addr_i[31:6], bus.led_addr_i[1:0],
                      bus.led_wdata_i[31:8]};

`ifdef LED_MATRIX_PWM_EN
  logic [7:0] r_bright;
  logic [7:0] r_pwm, w_pwm_nxt;

  assign w_bright = r_bright;

  // Brightness register lives next to EN in CTRL
  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_bright <= '0;
    else if (bus.led_we_i && w_widx == 4'd8)
      r_bright <= bus.led_wdata_i[15:8];
  end

  // PWM phase restarts at every SHOW entry and free-runs (wrapping) through SHOW
  always_comb begin
    w_pwm_nxt = '0;
    if (w_state_nxt == S_SHOW && r_state == S_SHOW)
      w_pwm_nxt = r_pwm + 8'd1;
    w_col_on = (r_bright == 8'hFF) || (w_pwm_nxt < r_bright);
  end

  // PWM phase register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_pwm <= '0;
    else       r_pwm <= w_pwm_nxt;
  end
`else
  assign w_bright = '0;
  assign w_col_on = 1'b1;
`endif

  // Register file writes: framebuffer rows and CTRL.EN; STATUS and holes ignore writes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) r_fb[i] <= '0;
      r_en <= 1'b0;
    end else if (bus.led_we_i) begin
      if (!w_widx[3])
        r_fb[w_widx[2:0]] <= bus.led_wdata_i[7:0];
      else if (w_widx == 4'd8)
        r_en <= bus.led_wdata_i[0];
    end
  end

  // Read mux over pre-edge state, so a read colliding with a write returns old data
  always_comb begin
    w_rdata_nxt = '0;
    if (!w_widx[3])
      w_rdata_nxt = {24'h0, r_fb[w_widx[2:0]]};
    else if (w_widx == 4'd8)
      w_rdata_nxt = {16'h0, w_bright, 7'h0, r_en};
    else if (w_widx == 4'd9)
      w_rdata_nxt = {16'h0, r_fcnt, 5'h0, r_idx};
  end

  // Scan FSM next state: clearing EN wins from any state and restarts the scan
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_fcnt_nxt  = r_fcnt;
    w_latch_nxt = r_latch;
    w_frame_nxt = 1'b0;
    if (!r_en) begin
      w_state_nxt = S_OFF;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_fcnt_nxt  = '0;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state_nxt = S_BLANK;
          w_cnt_nxt   = '0;
        end
        S_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_nxt = S_SHOW;
            w_cnt_nxt   = '0;
            w_latch_nxt = r_fb[r_idx];
          end else begin
            w_cnt_nxt = r_cnt + 16'd1;
          end
        end
        S_SHOW: begin
          if (r_cnt == SHOW_LAST) begin
            w_state_nxt = S_BLANK;
            w_cnt_nxt   = '0;
            w_idx_nxt   = r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              w_frame_nxt = 1'b1;
              w_fcnt_nxt  = r_fcnt + 8'd1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 16'd1;
          end
        end
        default: w_state_nxt = S_OFF;
      endcase
    end
  end

  // State, counters and registered pin/read outputs, all decoded from next state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_OFF;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_fcnt  <= '0;
      r_latch <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_frame <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_latch <= w_latch_nxt;
      r_row   <= (w_state_nxt == S_SHOW) ? (8'd1 << w_idx_nxt) : 8'h00;
      r_col   <= (w_state_nxt == S_SHOW && w_col_on) ? w_latch_nxt : 8'h00;
      r_frame <= w_frame_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

  assign row_o           = r_row;
  assign col_o           = r_col;
  assign frame_o         = r_frame;
  assign bus.led_rdata_o = r_rdata;

endmodule

// File: doc/led_matrix_ctrl.md
# led_matrix_ctrl

Memory-mapped 8x8 LED matrix controller. It sits directly downstream of the Wishbone LED slave adapter and consumes that adapter's flat address, write-data and write-enable signals. It holds an 8-row framebuffer plus control and status registers, returns registered read data, and drives a row-multiplexed scan with inter-row blanking to the matrix pins.

## Interface
- SCAN_DIV, 1000: clock cycles each row is lit (SHOW length), legal range 1..65535.
- BLANK_CYCLES, 2: cycles all outputs are dark between rows, legal range 1..255.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- led_addr_i  in  32  byte address; only [5:2] decoded, [31:6] and [1:0] ignored
- led_wdata_i  in  32  write data
- led_we_i  in  1  write strobe; sampled every edge
- led_rdata_o  out  32  registered read data
- row_o  out  8  one-hot row drive, active-high
- col_o  out  8  column drive, active-high
- frame_o  out  1  one-cycle pulse at end of row 7

## Operation
Register map (word index = addr[5:2]):
- 0x00–0x1C ROW0..ROW7: [7:0] pixels (bit n = column n). Reads are zero-extended.
- 0x20 CTRL: [0] EN, [15:8] BRIGHT (see Configuration). Other bits read 0.
- 0x24 STATUS (RO): [2:0] current row index, [15:8] frame counter (wraps 0xFF→0x00). Writes are ignored.
- 0x28–0x3C: read 0, writes ignored.

Writes:
- On every edge with led_we_i=1, the addressed register takes led_wdata_i.
- Repeated identical writes while the upstream holds we across its handshake are idempotent.

Reads:
- led_rdata_o at edge n+1 reflects the address presented before edge n+1. This gives 1-cycle latency, which meets the upstream ack one cycle after request.
- A read that coincides with a write to the same register returns the old value.

Scan FSM, states OFF, BLANK, SHOW:
- OFF: row_o=0, col_o=0, row index=0, cycle counter=0. Moves to BLANK on the first edge at which CTRL.EN=1.
- BLANK: outputs 0. Counter counts up to BLANK_CYCLES, then moves to SHOW.
  - On BLANK→SHOW, ROW[idx] is snapshotted into a column latch. Writes during SHOW take effect at the next visit to that row (no tearing).
- SHOW: row_o = 1<<idx, col_o = latch. After SCAN_DIV cycles, idx increments and the FSM moves to BLANK.
  - On the 7→0 wrap, frame_o pulses for the first BLANK cycle and the frame counter increments.
- EN cleared while in any state: FSM enters OFF on the next edge, and outputs are 0 from that edge.
  - idx and the frame counter reset to 0.
  - Framebuffer is retained.

Reset:
- All registers, framebuffer, FSM (OFF), counters and latch clear to 0.
- All outputs are 0 during and after reset, including led_rdata_o=0.
- Reset asserted mid-scan behaves identically to this.

## Timing
- Row period = BLANK_CYCLES + SCAN_DIV cycles. Frame = 8 row periods.
- CTRL write with EN=1 sampled at edge n: CTRL updates at edge n, BLANK starts at edge n+1, row 0 lights at edge n+1+BLANK_CYCLES.
- row_o, col_o and frame_o are registered outputs with no combinational path from inputs.
- Internal counter is 16 bits. The SCAN_DIV terminal count compares against SCAN_DIV-1.

## Configuration
- LED_MATRIX_PWM_EN defined: CTRL.BRIGHT[15:8] is read/write, with reset value 0x00.
  - An 8-bit PWM counter clears on entry to SHOW and increments each SHOW cycle, wrapping.
  - col_o = latch when BRIGHT==0xFF or pwm_cnt < BRIGHT; otherwise col_o = 0.
  - row_o is unaffected.
- LED_MATRIX_PWM_EN undefined: BRIGHT reads 0 and writes are ignored. No PWM logic is present, and col_o = latch throughout SHOW.

## Test plan
- Reset, then read all 16 words: every read is 0x00000000; row_o, col_o and frame_o stay 0 for 20 cycles.
- Write ROW3=0xFFFFFFA5, then read 0x0C: led_rdata_o=0x000000A5 one cycle later. Read 0x28: returns 0.
- SCAN_DIV=4, BLANK_CYCLES=2, ROW0=0x81, ROW1=0x18, write CTRL=1:
  - row_o=0x01 with col_o=0x81 for 4 cycles, then 2 dark cycles.
  - Then row_o=0x02 with col_o=0x18 for 4 cycles.
- Same setup run for 48+ cycles: frame_o is high for exactly one cycle per frame; STATUS[15:8] reads 1 after the first frame; the row index wraps from 7 to 0.
- Write ROW0=0x00 mid-SHOW of row 0: col_o holds the old value until the row ends. Clear EN mid-SHOW: outputs are 0 the next cycle and STATUS reads 0.
- With LED_MATRIX_PWM_EN, SCAN_DIV=512, BRIGHT=0x40: col_o is on for 64 cycles in each 256 SHOW cycles. With BRIGHT=0xFF, col_o is on for all 512 cycles.
